// File: rtl/spell_mem_param.sv
// spell_mem_param: SPELL core code/data memory with a programmable wait-state
// select/data_ready handshake and a write-only loader port that is served while idle.
module spell_mem_param #(
  parameter int CODE_SIZE   = 256,
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  select,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            data_in,
  input  logic                  memory_type_data,
  input  logic                  write,
  output logic [7:0]            data_out,
  output logic                  data_ready,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [7:0]            ld_data,
  input  logic                  ld_mem_data,
  output logic                  ld_ready
);
  // state | meaning
  // IDLE  | no core access in flight; loader writes accepted here only
  // WAIT  | core access pending, counting down wait states
  // DONE  | access performed once; data_ready held until select drops

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam int CODE_AW = $clog2(CODE_SIZE);
  localparam int DATA_AW = $clog2(DATA_SIZE);
  localparam logic [ADDR_WIDTH:0] CODE_LIM = (ADDR_WIDTH+1)'(CODE_SIZE);
  localparam logic [ADDR_WIDTH:0] DATA_LIM = (ADDR_WIDTH+1)'(DATA_SIZE);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic NO_WAIT = (WAIT_STATES == 0);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [7:0]            r_data_out;
  logic                  r_data_ready;
  logic [7:0]            r_code_mem [CODE_SIZE];
  logic [7:0]            r_data_mem [DATA_SIZE];

  logic                  w_ld_go;
  logic                  w_cpu_go;
  logic                  w_wr_en;
  logic                  w_wr_to_data;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [7:0]            w_wr_val;
  logic                  w_wr_code_ok;
  logic                  w_wr_data_ok;
  logic                  w_rd_code_ok;
  logic                  w_rd_data_ok;
  logic [7:0]            w_rd_val;
  logic [7:0]            w_acc_out;

  assign ld_ready   = (r_state == ST_IDLE);
  assign w_ld_go    = ld_ready && ld_valid;
  assign data_out   = r_data_out;
  assign data_ready = r_data_ready;

  // Edge on which the core access actually takes effect.
  always_comb begin
    w_cpu_go = 1'b0;
    case (r_state)
      ST_IDLE: w_cpu_go = !ld_valid && select && NO_WAIT;
      ST_WAIT: w_cpu_go = select && (r_cnt == 4'd0);
      default: w_cpu_go = 1'b0;
    endcase
  end

  // Loader and core share one write path; the loader only ever wins in IDLE.
  assign w_wr_en      = w_ld_go || (w_cpu_go && write);
  assign w_wr_to_data = w_ld_go ? ld_mem_data : memory_type_data;
  assign w_wr_addr    = w_ld_go ? ld_addr : addr;
  assign w_wr_val     = w_ld_go ? ld_data : data_in;
  assign w_wr_code_ok = ({1'b0, w_wr_addr} < CODE_LIM);
  assign w_wr_data_ok = ({1'b0, w_wr_addr} < DATA_LIM);
  assign w_rd_code_ok = ({1'b0, addr} < CODE_LIM);
  assign w_rd_data_ok = ({1'b0, addr} < DATA_LIM);

  always_comb begin
    w_rd_val = 8'h00;
    if (memory_type_data) begin
      w_rd_val = w_rd_data_ok ? r_data_mem[addr[DATA_AW-1:0]] : 8'h00;
    end else begin
      w_rd_val = w_rd_code_ok ? ~r_code_mem[addr[CODE_AW-1:0]] : 8'hFF;
    end
  end

  assign w_acc_out = write ? 8'h00 : w_rd_val;

  // Code is stored inverted so that a cleared array reads back as 8'hFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CODE_SIZE; i++) r_code_mem[i] <= 8'h00;
      for (int i = 0; i < DATA_SIZE; i++) r_data_mem[i] <= 8'h00;
    end else if (w_wr_en) begin
      if (w_wr_to_data) begin
        if (w_wr_data_ok) r_data_mem[w_wr_addr[DATA_AW-1:0]] <= w_wr_val;
      end else if (w_wr_code_ok) begin
        r_code_mem[w_wr_addr[CODE_AW-1:0]] <= ~w_wr_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_data_out   <= 8'h00;
      r_data_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!ld_valid && select) begin
            if (NO_WAIT) begin
              r_state      <= ST_DONE;
              r_data_ready <= 1'b1;
              r_data_out   <= w_acc_out;
            end else begin
              r_cnt   <= WS_LOAD;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!select) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state      <= ST_DONE;
            r_data_ready <= 1'b1;
            r_data_out   <= w_acc_out;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (!select) begin
            r_state      <= ST_IDLE;
            r_data_ready <= 1'b0;
            r_data_out   <= 8'h00;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spell_mem_param.sv
// tb_spell_mem_param: two memory instances (no wait states / 128-byte code, and
// three wait states / 256-byte code) checked against a byte-array reference model.
module tb_spell_mem_param;
  localparam int CS0 = 128;
  localparam int CS1 = 256;
  localparam int DS  = 32;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel [2];
  logic       wr  [2];
  logic       mtd [2];
  logic       ldv [2];
  logic       ldm [2];
  logic [7:0] adr [2];
  logic [7:0] din [2];
  logic [7:0] lda [2];
  logic [7:0] ldd [2];
  logic [7:0] dout [2];
  logic       rdy  [2];
  logic       ldr  [2];

  int code_m [2][256];
  int data_m [2][DS];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spell_mem_param #(.CODE_SIZE(CS0), .DATA_SIZE(DS), .ADDR_WIDTH(8), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst), .select(sel[0]), .addr(adr[0]), .data_in(din[0]),
    .memory_type_data(mtd[0]), .write(wr[0]), .data_out(dout[0]), .data_ready(rdy[0]),
    .ld_valid(ldv[0]), .ld_addr(lda[0]), .ld_data(ldd[0]), .ld_mem_data(ldm[0]), .ld_ready(ldr[0])
  );

  spell_mem_param #(.CODE_SIZE(CS1), .DATA_SIZE(DS), .ADDR_WIDTH(8), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst), .select(sel[1]), .addr(adr[1]), .data_in(din[1]),
    .memory_type_data(mtd[1]), .write(wr[1]), .data_out(dout[1]), .data_ready(rdy[1]),
    .ld_valid(ldv[1]), .ld_addr(lda[1]), .ld_data(ldd[1]), .ld_mem_data(ldm[1]), .ld_ready(ldr[1])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int csz(input int d);
    return (d == 0) ? CS0 : CS1;
  endfunction

  function automatic int wsn(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  // Reference: after reset code reads 8'hFF, data 8'h00; out-of-range ignored.
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) code_m[d][i] = 'hFF;
      for (int i = 0; i < DS; i++) data_m[d][i] = 'h00;
    end
  endtask

  task automatic model_write(input int d, input bit isd, input int a, input int v);
    if (isd) begin
      if (a < DS) data_m[d][a] = v;
    end else if (a < csz(d)) begin
      code_m[d][a] = v;
    end
  endtask

  function automatic int model_read(input int d, input bit isd, input int a);
    if (isd) return (a < DS) ? data_m[d][a] : 'h00;
    return (a < csz(d)) ? code_m[d][a] : 'hFF;
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      sel[d] = 0; wr[d] = 0; mtd[d] = 0; ldv[d] = 0; ldm[d] = 0;
      adr[d] = 0; din[d] = 0; lda[d] = 0; ldd[d] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ld_write(input int d, input bit isd, input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    ldv[d] = 1; ldm[d] = isd; lda[d] = a; ldd[d] = v;
    #1;
    chk("ld_ready", 32'(ldr[d]), 32'd1);
    @(posedge clk);
    model_write(d, isd, int'(a), int'(v));
    #1;
    ldv[d] = 0;
  endtask

  task automatic cpu_access(input int d, input bit isd, input bit w, input logic [7:0] a,
                            input logic [7:0] v, input int hold, input bit contend,
                            input bit lisd, input logic [7:0] la, input logic [7:0] lv);
    int         edges;
    logic [7:0] exp;
    @(negedge clk);
    sel[d] = 1; wr[d] = w; mtd[d] = isd; adr[d] = a; din[d] = v;
    if (contend) begin
      ldv[d] = 1; ldm[d] = lisd; lda[d] = la; ldd[d] = lv;
      model_write(d, lisd, int'(la), int'(lv));
    end
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      ldv[d] = 0;
    end while (!rdy[d] && edges < 40);
    chk("latency", 32'(edges), 32'(wsn(d) + 1 + int'(contend)));
    if (w) begin
      model_write(d, isd, int'(a), int'(v));
      exp = 8'h00;
    end else begin
      exp = 8'(model_read(d, isd, int'(a)));
    end
    chk(w ? "wr_dout" : "rd_dout", 32'(dout[d]), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      din[d] = ~v;
      @(posedge clk);
      #1;
      chk("hold_rdy", 32'(rdy[d]), 32'd1);
      chk("hold_dout", 32'(dout[d]), 32'(exp));
    end
    @(negedge clk);
    sel[d] = 0; wr[d] = 0;
    @(posedge clk);
    #1;
    chk("drop_rdy", 32'(rdy[d]), 32'd0);
    chk("drop_dout", 32'(dout[d]), 32'd0);
  endtask

  task automatic rd(input int d, input bit isd, input logic [7:0] a);
    cpu_access(d, isd, 1'b0, a, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wrt(input int d, input bit isd, input logic [7:0] a, input logic [7:0] v);
    cpu_access(d, isd, 1'b1, a, v, 0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Data write to addr 7 on the wait-state instance, aborted in WAIT by
  // dropping select (mode 0) or by a reset pulse (mode 1).
  task automatic abort_write(input bit mode, input logic [7:0] v);
    @(negedge clk);
    sel[1] = 1; wr[1] = 1; mtd[1] = 1; adr[1] = 8'h07; din[1] = v;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("abort_wait_rdy", 32'(rdy[1]), 32'd0);
    end
    @(negedge clk);
    if (mode) rst = 1'b1;
    else sel[1] = 0;
    @(posedge clk);
    #1;
    if (mode) model_reset();
    chk("abort_rdy", 32'(rdy[1]), 32'd0);
    chk("abort_dout", 32'(dout[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sel[1] = 0; wr[1] = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("abort_idle_rdy", 32'(rdy[1]), 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    do_reset();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'(rdy[d]), 32'd0);
      chk("rst_dout", 32'(dout[d]), 32'd0);
      chk("rst_ld_ready", 32'(ldr[d]), 32'd1);
    end

    rd(0, 1'b0, 8'h10);
    rd(0, 1'b1, 8'h05);

    wrt(1, 1'b1, 8'h07, 8'hA5);
    rd(1, 1'b1, 8'h07);

    wrt(0, 1'b1, 8'h20, 8'h77);
    rd(0, 1'b1, 8'h20);
    rd(0, 1'b1, 8'h00);
    rd(0, 1'b0, 8'h80);
    wrt(0, 1'b0, 8'h80, 8'h12);
    rd(0, 1'b0, 8'h00);
    wrt(0, 1'b1, 8'h1F, 8'hC3);
    rd(0, 1'b1, 8'h1F);
    wrt(0, 1'b0, 8'h7F, 8'h9E);
    rd(0, 1'b0, 8'h7F);

    cpu_access(0, 1'b1, 1'b1, 8'h03, 8'h5C, 10, 1'b0, 1'b0, 8'h00, 8'h00);
    rd(0, 1'b1, 8'h03);

    for (int d = 0; d < 2; d++) begin
      cpu_access(d, 1'b0, 1'b0, 8'h01, 8'h00, 0, 1'b1, 1'b0, 8'h01, 8'h3C);
    end

    abort_write(1'b0, 8'h5A);
    rd(1, 1'b1, 8'h07);
    wrt(1, 1'b1, 8'h09, 8'h44);
    abort_write(1'b1, 8'h66);
    rd(1, 1'b1, 8'h07);
    rd(1, 1'b1, 8'h09);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        int         op;
        bit         isd;
        logic [7:0] a;
        logic [7:0] v;
        op  = int'($urandom_range(0, 9));
        isd = 1'($urandom_range(0, 1));
        v   = 8'($urandom);
        if ($urandom_range(0, 3) == 0) a = 8'($urandom);
        else a = 8'($urandom_range(0, isd ? DS - 1 : csz(d) - 1));
        if (op < 3) ld_write(d, isd, a, v);
        else if (op < 6) rd(d, isd, a);
        else if (op < 9)
          cpu_access(d, isd, 1'b1, a, v, int'($urandom_range(0, 2)), 1'b0, 1'b0, 8'h00, 8'h00);
        else
          cpu_access(d, isd, 1'b0, a, 8'h00, 0, 1'b1, 1'($urandom_range(0, 1)),
                     (($urandom_range(0, 1) == 1) ? a : 8'($urandom)), 8'($urandom));
      end
      for (int i = 0; i < 256; i++) begin
        if (i % 7 == 0 || i >= 250 || i < 3) rd(d, 1'b0, 8'(i));
        if (i < 40 && i % 3 == 0) rd(d, 1'b1, 8'(i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
